// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock FIFO: address sizing, occupancy type
// and the read-mode encodings.
package sync_fifo_pkg;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // Wide occupancy used when comparing against integer thresholds.
  typedef logic [31:0] count_t;

  function automatic int addr_width(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

endpackage

// File: rtl/sfifo_ram.sv
// Storage array for sync_fifo_fwft: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module sfifo_ram #(
  parameter int data_width = 8,
  parameter int depth      = 16,
  parameter int addr_w     = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addr_w-1:0]     waddr,
  input  logic [data_width-1:0] wdata,
  input  logic [addr_w-1:0]     raddr,
  output logic [data_width-1:0] rdata
);

  logic [data_width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with selectable standard or first-word-fall-through read,
// occupancy count, threshold flags, flush and sticky error flags.
module sync_fifo_fwft
  import sync_fifo_pkg::*;
#(
  parameter int data_width = 8,
  parameter int depth      = 16,
  parameter int fwft       = 0,
  parameter int af_thresh  = 12,
  parameter int ae_thresh  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   w_en,
  input  logic [data_width-1:0]  data_in,
  input  logic                   r_en,
  input  logic                   flush,
  input  logic                   clr_err,
  output logic [data_width-1:0]  data_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(depth):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = addr_width(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);

  logic [AW-1:0]         wptr_q, wptr_d;
  logic [AW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [data_width-1:0] dout_q, dout_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [data_width-1:0] rd_data;
  logic                  wr_ok, rd_ok;

  sfifo_ram #(
    .data_width (data_width),
    .depth      (depth),
    .addr_w     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok && !flush),
    .waddr (wptr_q),
    .wdata (data_in),
    .raddr (rptr_q),
    .rdata (rd_data)
  );

  // Flags come only from the registered count, never from this cycle's requests.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_t'(count_q) >= count_t'(af_thresh));
  assign almost_empty = (count_t'(count_q) <= count_t'(ae_thresh));
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  assign wr_ok = w_en && !full;
  assign rd_ok = r_en && !empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + 1'b1;
      if (rd_ok) rptr_d = rptr_q + 1'b1;
      if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
      else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
      if (rd_ok && fwft == FWFT_OFF) dout_d = rd_data;
    end
    // A fresh error in the same cycle as clr_err must win, so it is applied last.
    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (!flush && w_en && full)  ovf_d = 1'b1;
    if (!flush && r_en && empty) unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // In FWFT mode the head word is shown directly, masked to zero while empty.
  assign data_out = (fwft == FWFT_ON) ? (empty ? '0 : rd_data) : dout_q;

endmodule
